// File: rtl/qpsk_pkg.sv
// Shared QPSK constants and types used by the mapper and demapper.
package qpsk_pkg;

   localparam logic signed [15:0] VAL_POS = 16'sd23170;
   localparam logic signed [15:0] VAL_NEG = -16'sd23170;

   typedef logic signed [15:0] iq_sample_t;
   typedef logic [1:0]         sym_idx_t;

   localparam int unsigned SYMS_PER_BYTE = 4;
   localparam sym_idx_t    LAST_IDX      = sym_idx_t'(SYMS_PER_BYTE - 1);

endpackage

// File: rtl/qpsk_slicer.sv
// Hard-decision slicer for one Q1.15 sample; with QPSK_DEMAP_ERASURE_EN it also
// flags samples whose saturated magnitude is below ERASE_THRESH.
module qpsk_slicer
   import qpsk_pkg::*;
`ifdef QPSK_DEMAP_ERASURE_EN
#(
   parameter logic [15:0] ERASE_THRESH = 16'd2048
)
`endif
(
   input  iq_sample_t i_sample,
`ifdef QPSK_DEMAP_ERASURE_EN
   output logic       o_low_conf,
`endif
   output logic       o_bit
);

   // Exact zero slices to 1.
   assign o_bit = ~i_sample[15];

`ifdef QPSK_DEMAP_ERASURE_EN
   logic [15:0] w_mag;

   always_comb begin
      if (i_sample == 16'sh8000) begin
         w_mag = 16'h7fff;
      end else if (i_sample[15]) begin
         w_mag = 16'(-i_sample);
      end else begin
         w_mag = i_sample;
      end
   end

   assign o_low_conf = (w_mag < ERASE_THRESH);
`endif

endmodule

// File: rtl/qpsk_demapper.sv
// QPSK hard demapper: packs 4 sliced symbols MSB-first into a byte with sidebands.
// Optional byte erasure output enabled by QPSK_DEMAP_ERASURE_EN.
module qpsk_demapper
   import qpsk_pkg::*;
`ifdef QPSK_DEMAP_ERASURE_EN
#(
   parameter logic [15:0] ERASE_THRESH = 16'd2048
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_axis_valid,
   output logic       s_axis_ready,
   input  iq_sample_t s_axis_i,
   input  iq_sample_t s_axis_q,
   input  logic       s_axis_last,
   input  logic       s_axis_sop,
   input  logic       s_axis_is_parity,
   output logic       m_axis_valid,
   input  logic       m_axis_ready,
   output logic [7:0] m_axis_data,
   output logic       m_axis_last,
   output logic       m_axis_sop,
   output logic       m_axis_is_parity,
`ifdef QPSK_DEMAP_ERASURE_EN
   output logic       m_axis_erase,
`endif
   output logic       err_short,
   output logic       err_resync
);

   logic       w_i_bit, w_q_bit;
   logic       w_accept, w_first, w_complete;
   sym_idx_t   w_idx;
   logic [7:0] w_base, w_byte;
   logic       w_sop_cur, w_par_cur;

   sym_idx_t   r_count;
   logic [7:0] r_acc;
   logic       r_sop, r_par;
   logic       r_out_valid, r_out_last, r_out_sop, r_out_par;
   logic [7:0] r_out_data;
   logic       r_err_short, r_err_resync;

`ifdef QPSK_DEMAP_ERASURE_EN
   logic w_i_low, w_q_low, w_erase_cur;
   logic r_erase, r_out_erase;

   qpsk_slicer #(.ERASE_THRESH(ERASE_THRESH)) u_slicer_i (
      .i_sample   (s_axis_i),
      .o_low_conf (w_i_low),
      .o_bit      (w_i_bit)
   );
   qpsk_slicer #(.ERASE_THRESH(ERASE_THRESH)) u_slicer_q (
      .i_sample   (s_axis_q),
      .o_low_conf (w_q_low),
      .o_bit      (w_q_bit)
   );

   assign w_erase_cur  = (w_first ? 1'b0 : r_erase) | w_i_low | w_q_low;
   assign m_axis_erase = r_out_erase;
`else
   qpsk_slicer u_slicer_i (
      .i_sample (s_axis_i),
      .o_bit    (w_i_bit)
   );
   qpsk_slicer u_slicer_q (
      .i_sample (s_axis_q),
      .o_bit    (w_q_bit)
   );
`endif

   assign s_axis_ready = !r_out_valid || m_axis_ready;
   assign w_accept     = s_axis_valid && s_axis_ready;

   // A sop restarts the byte regardless of the current count.
   always_comb begin
      w_idx   = s_axis_sop ? sym_idx_t'(0) : r_count;
      w_first = (w_idx == sym_idx_t'(0));
      w_base  = w_first ? 8'h00 : r_acc;
      w_byte  = w_base;
      unique case (w_idx)
         2'd0: w_byte[7:6] = {w_i_bit, w_q_bit};
         2'd1: w_byte[5:4] = {w_i_bit, w_q_bit};
         2'd2: w_byte[3:2] = {w_i_bit, w_q_bit};
         2'd3: w_byte[1:0] = {w_i_bit, w_q_bit};
      endcase
   end

   assign w_sop_cur  = w_first ? s_axis_sop       : r_sop;
   assign w_par_cur  = w_first ? s_axis_is_parity : r_par;
   assign w_complete = w_accept && ((w_idx == LAST_IDX) || s_axis_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count      <= '0;
         r_acc        <= '0;
         r_sop        <= 1'b0;
         r_par        <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_last   <= 1'b0;
         r_out_sop    <= 1'b0;
         r_out_par    <= 1'b0;
         r_err_short  <= 1'b0;
         r_err_resync <= 1'b0;
`ifdef QPSK_DEMAP_ERASURE_EN
         r_erase      <= 1'b0;
         r_out_erase  <= 1'b0;
`endif
      end else begin
         r_err_short  <= 1'b0;
         r_err_resync <= w_accept && s_axis_sop && (r_count != sym_idx_t'(0));

         if (w_accept) begin
            if (w_complete) begin
               r_count <= '0;
               r_acc   <= '0;
            end else begin
               r_count <= w_idx + 2'd1;
               r_acc   <= w_byte;
               r_sop   <= w_sop_cur;
               r_par   <= w_par_cur;
            end
`ifdef QPSK_DEMAP_ERASURE_EN
            r_erase <= w_complete ? 1'b0 : w_erase_cur;
`endif
         end

         // Slot reloads when a byte completes in the same cycle as the handshake.
         if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_byte;
            r_out_last  <= s_axis_last;
            r_out_sop   <= w_sop_cur;
            r_out_par   <= w_par_cur;
            r_err_short <= s_axis_last && (w_idx != LAST_IDX);
`ifdef QPSK_DEMAP_ERASURE_EN
            r_out_erase <= w_erase_cur;
`endif
         end else if (m_axis_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign m_axis_valid     = r_out_valid;
   assign m_axis_data      = r_out_data;
   assign m_axis_last      = r_out_last;
   assign m_axis_sop       = r_out_sop;
   assign m_axis_is_parity = r_out_par;
   assign err_short        = r_err_short;
   assign err_resync       = r_err_resync;

endmodule

// File: tb/tb_qpsk_demapper.sv
// Scoreboard bench for qpsk_demapper: directed symbol streams, expected bytes queued at issue.
module tb_qpsk_demapper;
   import qpsk_pkg::*;

`ifdef QPSK_DEMAP_ERASURE_EN
   localparam bit ERASE_ON = 1'b1;
`else
   localparam bit ERASE_ON = 1'b0;
`endif

   localparam logic signed [15:0] P = VAL_POS;
   localparam logic signed [15:0] N = VAL_NEG;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       sop;
      logic       par;
      logic       erase;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0, n_fail = 0, n_short = 0, n_resync = 0;
   bit   rdy_rand = 1'b0;

   logic             clk, rst_n;
   logic             s_axis_valid, s_axis_ready;
   logic signed [15:0] s_axis_i, s_axis_q;
   logic             s_axis_last, s_axis_sop, s_axis_is_parity;
   logic             m_axis_valid, m_axis_ready;
   logic [7:0]       m_axis_data;
   logic             m_axis_last, m_axis_sop, m_axis_is_parity;
   logic             err_short, err_resync;
   logic             erase_obs;

   qpsk_demapper dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_axis_valid     (s_axis_valid),
      .s_axis_ready     (s_axis_ready),
      .s_axis_i         (s_axis_i),
      .s_axis_q         (s_axis_q),
      .s_axis_last      (s_axis_last),
      .s_axis_sop       (s_axis_sop),
      .s_axis_is_parity (s_axis_is_parity),
      .m_axis_valid     (m_axis_valid),
      .m_axis_ready     (m_axis_ready),
      .m_axis_data      (m_axis_data),
      .m_axis_last      (m_axis_last),
      .m_axis_sop       (m_axis_sop),
      .m_axis_is_parity (m_axis_is_parity),
`ifdef QPSK_DEMAP_ERASURE_EN
      .m_axis_erase     (erase_obs),
`endif
      .err_short        (err_short),
      .err_resync       (err_resync)
   );

`ifndef QPSK_DEMAP_ERASURE_EN
   assign erase_obs = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ready changes just after the rising edge so both sides sample it stably at negedge.
   initial m_axis_ready = 1'b1;
   always @(posedge clk) begin
      #1;
      m_axis_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      exp_t e, g;
      if (rst_n) begin
         if (err_short)  n_short++;
         if (err_resync) n_resync++;
         if (m_axis_valid && m_axis_ready) begin
            n_vec++;
            g = '{data: m_axis_data, last: m_axis_last, sop: m_axis_sop,
                  par: m_axis_is_parity, erase: erase_obs};
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_byte: got data=%h last=%b sop=%b par=%b, none expected",
                        g.data, g.last, g.sop, g.par);
            end else begin
               e = sbq.pop_front();
               e.erase = e.erase & ERASE_ON;
               if (g !== e) begin
                  n_fail++;
                  $display("FAIL byte: got data=%h last=%b sop=%b par=%b erase=%b, want data=%h last=%b sop=%b par=%b erase=%b",
                           g.data, g.last, g.sop, g.par, g.erase,
                           e.data, e.last, e.sop, e.par, e.erase);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input logic signed [15:0] i, input logic signed [15:0] q,
                       input bit sop, input bit last, input bit par);
      int n;
      bit got;
      s_axis_valid     = 1'b1;
      s_axis_i         = i;
      s_axis_q         = q;
      s_axis_sop       = sop;
      s_axis_last      = last;
      s_axis_is_parity = par;
      n = 0;
      forever begin
         got = s_axis_ready;
         @(negedge clk);
         if (got) break;
         n++;
         if (n > 200) begin
            n_fail++;
            $display("FAIL accept_timeout: symbol not accepted within 200 cycles");
            break;
         end
      end
   endtask

   task automatic idle();
      s_axis_valid = 1'b0;
      s_axis_sop   = 1'b0;
      s_axis_last  = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit sop, input bit last, input bit par);
      sbq.push_back('{data: b, last: last, sop: sop, par: par, erase: 1'b0});
      for (int k = 0; k < 4; k++) begin
         send(b[7-2*k] ? P : N, b[6-2*k] ? P : N, sop && (k == 0), last && (k == 3), par);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk(name, sbq.size(), 0);
   endtask

   logic [7:0] frame [8];

   initial begin
      frame = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h81, 8'h7E};
      rst_n = 1'b0;
      s_axis_valid = 1'b0;
      s_axis_i = '0;
      s_axis_q = '0;
      s_axis_sop = 1'b0;
      s_axis_last = 1'b0;
      s_axis_is_parity = 1'b0;
      repeat (3) @(negedge clk);

      chk("reset_valid",  m_axis_valid, 0);
      chk("reset_data",   m_axis_data, 0);
      chk("reset_flags",  {m_axis_last, m_axis_sop, m_axis_is_parity, erase_obs}, 0);
      chk("reset_errs",   {err_short, err_resync}, 0);
      chk("reset_ready",  s_axis_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic byte 0x9C, valid one cycle after the fourth accept.
      sbq.push_back('{data: 8'h9C, last: 1'b1, sop: 1'b1, par: 1'b0, erase: 1'b0});
      send(P, N, 1, 0, 0);
      send(N, P, 0, 0, 0);
      send(P, P, 0, 0, 0);
      send(N, N, 0, 1, 0);
      chk("latency_valid", m_axis_valid, 1);
      chk("latency_data", m_axis_data, 8'h9C);
      idle();
      drain("drain_9c");

      // Mapped frame with backpressure; last two bytes flagged as parity.
      rdy_rand = 1'b1;
      for (int b = 0; b < 8; b++) begin
         send_byte(frame[b], b == 0, b == 7, b >= 6);
      end
      idle();
      drain("drain_frame");
      rdy_rand = 1'b0;
      @(negedge clk);

      // Short frame: 2 symbols ending with last.
      sbq.push_back('{data: 8'hE0, last: 1'b1, sop: 1'b1, par: 1'b0, erase: 1'b1});
      send(16'sd1, 16'sd1, 1, 0, 0);
      send(16'sd1, -16'sd1, 0, 1, 0);
      idle();
      drain("drain_short");

      // sop arrives at count=2; partial byte is discarded.
      send(P, P, 1, 0, 0);
      send(N, N, 0, 0, 0);
      sbq.push_back('{data: 8'hD8, last: 1'b1, sop: 1'b1, par: 1'b0, erase: 1'b0});
      send(P, P, 1, 0, 0);
      send(N, P, 0, 0, 0);
      send(P, N, 0, 0, 0);
      send(N, N, 0, 1, 0);
      idle();
      drain("drain_resync");

      // Zero slices to 1, -32768 to 0; zero is low confidence.
      sbq.push_back('{data: 8'h9C, last: 1'b1, sop: 1'b1, par: 1'b0, erase: 1'b1});
      send(16'sd0, -16'sd32768, 1, 0, 0);
      send(-16'sd32768, 16'sd0, 0, 0, 0);
      send(16'sd0, 16'sd0, 0, 0, 0);
      send(-16'sd32768, -16'sd32768, 0, 1, 0);
      // A single weak sample in symbol 0 marks the whole byte.
      sbq.push_back('{data: 8'hFF, last: 1'b1, sop: 1'b1, par: 1'b1, erase: 1'b1});
      send(16'sd100, P, 1, 0, 1);
      send(P, P, 0, 0, 1);
      send(P, P, 0, 0, 1);
      send(P, P, 0, 1, 1);
      idle();
      drain("drain_edge");

      // Reset mid-byte: only the fresh symbols form a byte.
      send(P, P, 1, 0, 0);
      send(P, P, 0, 0, 0);
      send(P, P, 0, 0, 0);
      s_axis_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_valid", m_axis_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      sbq.push_back('{data: 8'h0B, last: 1'b1, sop: 1'b1, par: 1'b0, erase: 1'b0});
      send(N, N, 1, 0, 0);
      send(N, N, 0, 0, 0);
      send(P, N, 0, 0, 0);
      send(P, P, 0, 1, 0);
      idle();
      drain("drain_reset");

      chk("err_short_pulses", n_short, 1);
      chk("err_resync_pulses", n_resync, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
